// File: rtl/line_clear_engine.sv
// line_clear_engine: drops every full row of a ROWS x COLS playfield and collapses the rest downward; done pulses ROWS+k+1 cycles
// after the start edge, start is ignored while busy (no backpressure). Define LINE_CLEAR_SCORE_EN to add the saturating score output.
module line_clear_engine #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ROWS-1:0][COLS-1:0]  screen_in,
  output logic                       busy,
  output logic                       done,
  output logic [ROWS-1:0][COLS-1:0]  screen_out,
  output logic [4:0]                 lines_cleared,
  output logic [15:0]                total_lines
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [19:0]                score
`endif
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t                      state;
  logic [ROWS-1:0][COLS-1:0]   buffer;
  logic [ROWS-1:0][COLS-1:0]   shifted;
  logic [RW-1:0]               r;
  logic [4:0]                  k;
  logic [15:0]                 tot_q;
  logic [16:0]                 tot_sum;
  logic                        row_full;
  logic                        shifted_full;

  // Rows at and above r move down by one; the top row is always refilled with zeros.
  always_comb begin
    shifted = buffer;
    for (int i = 0; i < ROWS - 1; i++) begin
      if (i >= int'(r)) shifted[i] = buffer[i+1];
    end
    shifted[ROWS-1] = '0;
  end

  assign row_full     = &buffer[r];
  assign shifted_full = &shifted[r];
  assign tot_sum      = {1'b0, tot_q} + {12'd0, k};
  assign total_lines  = tot_q;

`ifdef LINE_CLEAR_SCORE_EN
  logic [19:0] score_q;
  logic [20:0] score_sum;
  logic [10:0] gain;

  always_comb begin
    gain = 11'd0;
    case (k)
      5'd0:    gain = 11'd0;
      5'd1:    gain = 11'd40;
      5'd2:    gain = 11'd100;
      5'd3:    gain = 11'd300;
      default: gain = 11'd1200;
    endcase
  end

  assign score_sum = {1'b0, score_q} + {10'd0, gain};
  assign score     = score_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      screen_out    <= '0;
      lines_cleared <= '0;
      tot_q         <= '0;
      buffer        <= '0;
      r             <= '0;
      k             <= '0;
`ifdef LINE_CLEAR_SCORE_EN
      score_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= start;
          if (start) begin
            buffer <= screen_in;
            r      <= '0;
            k      <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (row_full) begin
            state <= SHIFT;
          end else if (r == LAST) begin
            state <= DONE;
          end else begin
            r <= r + 1'b1;
          end
        end
        SHIFT: begin
          // The row falling into r is re-tested here, so a run of full rows costs one cycle per row.
          buffer <= shifted;
          k      <= k + 1'b1;
          if (!shifted_full) begin
            if (r == LAST) begin
              state <= DONE;
            end else begin
              r     <= r + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          screen_out    <= buffer;
          lines_cleared <= k;
          tot_q         <= tot_sum[16] ? 16'hFFFF : tot_sum[15:0];
          done          <= 1'b1;
          state         <= IDLE;
`ifdef LINE_CLEAR_SCORE_EN
          score_q       <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: directed and random playfields checked against a queue-based collapse model.
module tb_line_clear_engine;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  typedef logic [ROWS-1:0][COLS-1:0] scr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  scr_t        screen_in = '0;
  logic        busy;
  logic        done;
  scr_t        screen_out;
  logic [4:0]  lines_cleared;
  logic [15:0] total_lines;
`ifdef LINE_CLEAR_SCORE_EN
  logic [19:0] score;
`endif

  int          checks = 0;
  int          passed = 0;
  logic [15:0] exp_total = '0;
  logic [19:0] exp_score = '0;

  line_clear_engine #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .screen_in     (screen_in),
    .busy          (busy),
    .done          (done),
    .screen_out    (screen_out),
    .lines_cleared (lines_cleared),
    .total_lines   (total_lines)
`ifdef LINE_CLEAR_SCORE_EN
    ,
    .score         (score)
`endif
  );

  always #5 clk = ~clk;

  // Keep every non-full row in order, stack them from the bottom, pad with empty rows.
  function automatic void model(input scr_t s, output scr_t o, output int k);
    logic [COLS-1:0] keep[$];
    logic [COLS-1:0] full_row;
    full_row = '1;
    for (int i = 0; i < ROWS; i++) begin
      if (s[i] != full_row) keep.push_back(s[i]);
    end
    o = '0;
    for (int i = 0; i < keep.size(); i++) o[i] = keep[i];
    k = ROWS - keep.size();
  endfunction

  function automatic int score_gain(input int k);
    if (k == 0) return 0;
    if (k == 1) return 40;
    if (k == 2) return 100;
    if (k == 3) return 300;
    return 1200;
  endfunction

  function automatic scr_t rand_screen();
    scr_t s;
    for (int i = 0; i < ROWS; i++) begin
      if ($urandom_range(0, 2) == 0) s[i] = '1;
      else s[i] = COLS'($urandom);
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_pass(input scr_t scr, input bit restart, input string tag);
    scr_t exp_scr;
    int   k;
    int   m;
    int   t;
    int   extra;
    bit   seen;
    bit   busy_ok;
    model(scr, exp_scr, k);
    @(negedge clk);
    screen_in = scr;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    screen_in = rand_screen();
    m = 0;
    seen = 1'b0;
    busy_ok = busy;
    while (!seen && m < 200) begin
      @(negedge clk);
      m++;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
      if (restart && m == 5) begin
        start     = 1'b1;
        screen_in = '1;
      end
      if (restart && m == 6) start = 1'b0;
    end
    t = int'(exp_total) + k;
    exp_total = (t > 65535) ? 16'hFFFF : 16'(t);
    t = int'(exp_score) + score_gain(k);
    exp_score = (t > 20'hFFFFF) ? 20'hFFFFF : 20'(t);
    check({tag, "_done_seen"}, 256'(seen), 256'(1));
    check({tag, "_latency"}, 256'(m), 256'(ROWS + k + 1));
    check({tag, "_busy_held"}, 256'(busy_ok && busy), 256'(1));
    check({tag, "_screen"}, 256'(screen_out), 256'(exp_scr));
    check({tag, "_lines"}, 256'(lines_cleared), 256'(k));
    check({tag, "_total"}, 256'(total_lines), 256'(exp_total));
`ifdef LINE_CLEAR_SCORE_EN
    check({tag, "_score"}, 256'(score), 256'(exp_score));
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, 256'({done, busy}), 256'(0));
    if (restart) begin
      extra = 0;
      repeat (45) begin
        @(negedge clk);
        if (done) extra++;
      end
      check({tag, "_no_second_done"}, 256'(extra), 256'(0));
      check({tag, "_screen_held"}, 256'(screen_out), 256'(exp_scr));
    end
  endtask

  initial begin
    scr_t s;
    int   dn;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy_done", 256'({busy, done}), 256'(0));
    check("rst_screen", 256'(screen_out), 256'(0));
    check("rst_lines", 256'(lines_cleared), 256'(0));
    check("rst_total", 256'(total_lines), 256'(0));
`ifdef LINE_CLEAR_SCORE_EN
    check("rst_score", 256'(score), 256'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    s = '0;
    run_pass(s, 1'b0, "empty");

    s = '0;
    s[0] = '1;
    s[1] = '1;
    s[2] = 10'h001;
    run_pass(s, 1'b0, "two_rows");
    check("two_rows_row0", 256'(screen_out[0]), 256'(10'h001));
    check("two_rows_cnt", 256'(lines_cleared), 256'(2));

    s = '1;
    run_pass(s, 1'b0, "all_full");
    check("all_full_zero", 256'(screen_out), 256'(0));

    s = '0;
    s[19] = '1;
    s[5]  = 10'h155;
    run_pass(s, 1'b0, "top_row");
    check("top_row_r19", 256'(screen_out[19]), 256'(0));

    s = '0;
    s[19] = '1;
    run_pass(s, 1'b1, "restart_ignored");

    for (int n = 0; n < 15; n++) begin
      run_pass(rand_screen(), 1'b0, "random");
    end

    s = '0;
    s[3] = '1;
    s[4] = '1;
    @(negedge clk);
    screen_in = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_total = '0;
    exp_score = '0;
    dn = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("midrst_no_done", 256'(dn), 256'(0));
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_total", 256'(total_lines), 256'(0));
    check("midrst_screen", 256'(screen_out), 256'(0));

    force dut.tot_q = 16'hFFFE;
    @(negedge clk);
    release dut.tot_q;
    @(negedge clk);
    exp_total = 16'hFFFE;
    check("preload_total", 256'(total_lines), 256'(16'hFFFE));
    s = '0;
    s[0] = '1;
    s[7] = '1;
    s[8] = '1;
    s[9] = 10'h3F0;
    run_pass(s, 1'b0, "sat3");
    check("sat3_ffff", 256'(total_lines), 256'(16'hFFFF));
    s = '0;
    s[2] = '1;
    run_pass(s, 1'b0, "sat_hold");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

endmodule
